mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and select controller for the 4:1 mux datapath.
- Shares one output between four requesters and drives the mux select pair {S1,S0} from a registered grant.
- Bounds how long any requester can hold the output, for fairness.
- Sits directly in front of the 4:1 mux; each requester owns one mux input.

Parameters:
DATA_W, 1, width of each requester data input and of y.
MAX_HOLD, 8, maximum consecutive granted cycles while others wait; legal range 1..255.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
req  input  4  request vector; bit i = requester i wants the output.
din0  input  DATA_W  requester 0 data (mux input I0).
din1  input  DATA_W  requester 1 data (I1).
din2  input  DATA_W  requester 2 data (I2).
din3  input  DATA_W  requester 3 data (I3).
gnt  output  4  one-hot grant, registered.
sel  output  2  mux select {S1,S0} = granted index, registered.
y  output  DATA_W  muxed data: din[sel] when busy, else 0.
busy  output  1  a grant is active.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - state=IDLE, gnt=0, sel=2'b00, busy=0, y=0.
  - Hold counter hcnt=0.
  - Last-served pointer ptr=3, so requester 0 has highest priority first.
- Priority search: scan indices ptr+1, ptr+2, ptr+3, ptr (mod 4). The first index with its req bit set wins.
- IDLE:
  - If req!=0, at the next edge go to GRANT: gnt=onehot(win), sel=win, busy=1, hcnt=1.
  - Latency: req sampled at edge N gives gnt/sel/busy valid after edge N (one clock).
  - If req==0, stay IDLE. sel keeps its last value (no select toggling); gnt=0, busy=0.
- GRANT, evaluated at each edge, with g=sel:
  - Release (req[g]=0):
    - Set ptr=g.
    - If any other req is set, re-arbitrate from the new ptr on the same edge: back-to-back grant, no idle cycle, hcnt=1.
    - Otherwise go to IDLE with gnt=0, busy=0.
  - Preempt (req[g]=1, hcnt==MAX_HOLD, and another req is set): set ptr=g and grant the winner from the new ptr on the same edge, hcnt=1.
  - Continue (req[g]=1, no preemption): keep the grant. hcnt increments and saturates at MAX_HOLD; a lone requester holds indefinitely.
- New requests during GRANT are considered only at release or preemption, never mid-hold.
- Requester 3 wraps to requester 0 in the search.
- gnt is always one-hot or zero. sel changes only on a grant change.
- y is a combinational mux of din0..din3 by sel, gated by busy. There are no registers on the data path, so data latency is zero.
- Widths:
  - hcnt is 8 bits; MAX_HOLD > 255 is illegal.
  - ptr and sel are 2 bits; wrap-around is natural mod-4 overflow.
- FSM: two states, IDLE and GRANT. Single clocked process plus a combinational next-state block.

Decomposition:
- Shared package mux_arb_pkg holds:
  - N_REQ=4, SEL_W=2.
  - State encoding ST_IDLE=1'b0, ST_GRANT=1'b1.
  - HCNT_W=8.
- One sub-module, rr_pick: a combinational priority picker.
  - Inputs req[3:0], ptr[1:0].
  - Outputs win[1:0], found.
  - Instantiated once, shared by the IDLE and release/preempt paths.

Test Plan:
(Bench overrides MAX_HOLD=4, DATA_W=1, din0..din3 = 0,1,0,1.)
- Reset check: assert rst mid-grant between edges -> gnt=0000, sel=00, busy=0, y=0 immediately, with no clock edge needed.
- Single requester: req=0100 from IDLE -> after one edge gnt=0100, sel=10, busy=1, y=0. Held past 10 cycles with no preemption. Drop req -> next edge gnt=0000, busy=0, sel stays 10.
- Round-robin order: after reset, req=1111 held, each requester dropping its req after 2 granted cycles -> grants in order 0,1,2,3,0, back-to-back, no idle cycles; y follows 0,1,0,1,0.
- Preemption: req=0011 held continuously -> gnt=0001 for exactly 4 cycles, then 0010 for 4 cycles, then 0001, alternating.
- Wrap and skip: ptr=2 (last served requester 2), req=1001 -> grant goes to 3. After release and a pending req=0001, the next grant is 0 with sel=00.
- Late arrival: during a grant to requester 1 (hcnt=2), req[0] rises -> no change until requester 1 releases or hcnt reaches 4. Then grant 0.

Source files
------------

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants and helpers for the 4-way round-robin arbiter.
// Holds the state encoding and the common widths.
package mux_arb_pkg;
  localparam int N_REQ  = 4;
  localparam int SEL_W  = 2;
  localparam int HCNT_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: scans ptr+1, ptr+2, ptr+3, ptr (mod 4).
// The first index in that order with its request bit set wins.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] win,
  output logic             found
);
  logic [SEL_W-1:0] idx;

  // Walk from the lowest priority up so the highest-priority hit is written last.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the select of a 4:1 mux, with a bounded hold time.
// Grant and select are registered; the data path is a purely combinational mux.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  input  logic [DATA_W-1:0] din3,
  output logic [N_REQ-1:0]  gnt,
  output logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] y,
  output logic              busy
);
  localparam logic [HCNT_W-1:0] MAXH = HCNT_W'(MAX_HOLD);

  arb_state_e        state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic              busy_q, busy_d;

  logic              holder_req, others_req, rearb;
  logic [SEL_W-1:0]  pick_ptr, win;
  logic              found;

  assign holder_req = req[sel_q];
  assign others_req = |(req & ~onehot(sel_q));
  // Release or preemption re-arbitrates from the current holder's index.
  assign rearb      = (state_q == ST_GRANT) &&
                      (!holder_req || (hcnt_q == MAXH && others_req));
  assign pick_ptr   = rearb ? sel_q : ptr_q;

  rr_pick u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .win   (win),
    .found (found)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    hcnt_d  = hcnt_q;
    busy_d  = busy_q;
    if (state_q == ST_IDLE || rearb) begin
      if (rearb) ptr_d = sel_q;
      if (found) begin
        state_d = ST_GRANT;
        gnt_d   = onehot(win);
        sel_d   = win;
        busy_d  = 1'b1;
        hcnt_d  = HCNT_W'(1);
      end else begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        hcnt_d  = '0;
      end
    end else if (hcnt_q != MAXH) begin
      hcnt_d = hcnt_q + HCNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= SEL_W'(N_REQ - 1);
      hcnt_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    y = '0;
    if (busy_q) begin
      unique case (sel_q)
        2'd0: y = din0;
        2'd1: y = din1;
        2'd2: y = din2;
        default: y = din3;
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios plus random requests, checked
// against a behavioural arbiter model through an expected-response queue.
module tb_mux4_rr_arbiter;
  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [0:0] din0 = 1'b0, din1 = 1'b1, din2 = 1'b0, din3 = 1'b1;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic [0:0] y;
  logic       busy;

  mux4_rr_arbiter #(.DATA_W(1), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req(req),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .gnt(gnt), .sel(sel), .y(y), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       y;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: plain integers, following the arbitration rules directly.
  int m_busy, m_g, m_sel, m_ptr, m_hcnt;
  int din_v[4] = '{0, 1, 0, 1};

  function automatic int search(int p, logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic void m_reset();
    m_busy = 0; m_g = 0; m_sel = 0; m_ptr = 3; m_hcnt = 0;
  endfunction

  function automatic void m_grant_from(logic [3:0] r);
    int w;
    w = search(m_ptr, r);
    if (w < 0) begin
      m_busy = 0; m_hcnt = 0;
    end else begin
      m_busy = 1; m_g = w; m_sel = w; m_hcnt = 1;
    end
  endfunction

  function automatic void m_step(logic [3:0] r);
    logic [3:0] others;
    others = r;
    others[m_g] = 1'b0;
    if (m_busy == 0) m_grant_from(r);
    else if (!r[m_g]) begin
      m_ptr = m_g; m_grant_from(r);
    end else if (m_hcnt == MH && others != 0) begin
      m_ptr = m_g; m_grant_from(r);
    end else if (m_hcnt < MH) m_hcnt++;
  endfunction

  function automatic exp_t m_out();
    exp_t e;
    e.gnt  = m_busy ? 4'(1 << m_g) : 4'b0;
    e.sel  = 2'(m_sel);
    e.busy = m_busy != 0;
    e.y    = m_busy ? din_v[m_sel][0] : 1'b0;
    return e;
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: after each rising edge compare DUT outputs with the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("gnt",  8'(gnt),  8'(e.gnt));
      check("sel",  8'(sel),  8'(e.sel));
      check("busy", 8'(busy), 8'(e.busy));
      check("y",    8'(y),    8'(e.y));
    end
  end

  task automatic step(logic [3:0] r);
    @(negedge clk);
    req = r;
    m_step(r);
    exp_q.push_back(m_out());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    m_reset();
    @(negedge clk);
    #1;
    check("rst_gnt",  8'(gnt),  8'h0);
    check("rst_busy", 8'(busy), 8'h0);
    check("rst_sel",  8'(sel),  8'h0);
    rst = 1'b0;

    // Single requester 2, held long with no preemption, then dropped.
    for (int i = 0; i < 12; i++) step(4'b0100);
    step(4'b0000);
    step(4'b0000);

    // Round-robin order with each holder dropping after two granted cycles.
    do_reset();
    begin
      logic [3:0] rr_tab[10] = '{4'b1111, 4'b1111, 4'b1110, 4'b1110, 4'b1100,
                                 4'b1100, 4'b1000, 4'b1000, 4'b0111, 4'b0111};
      for (int i = 0; i < 10; i++) step(rr_tab[i]);
    end
    step(4'b0000);

    // Preemption between requesters 0 and 1.
    do_reset();
    for (int i = 0; i < 17; i++) step(4'b0011);
    step(4'b0000);

    // Wrap and skip: last served 2, then 3 and 0 pending.
    do_reset();
    step(4'b0100);
    step(4'b1001);
    step(4'b0001);
    step(4'b0000);

    // Late arrival during a grant to requester 1.
    do_reset();
    step(4'b0010);
    step(4'b0010);
    for (int i = 0; i < 4; i++) step(4'b0011);
    step(4'b0000);

    // Random traffic, biased toward holding the current pattern.
    begin
      logic [3:0] r;
      r = '0;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(3) == 0) r = 4'($urandom);
        step(r);
      end
    end

    // Asynchronous reset between edges while a grant is active.
    step(4'b0010);
    step(4'b0010);
    @(posedge clk);
    #3;
    rst = 1'b1;
    m_reset();
    #1;
    check("arst_gnt",  8'(gnt),  8'h0);
    check("arst_sel",  8'(sel),  8'h0);
    check("arst_busy", 8'(busy), 8'h0);
    check("arst_y",    8'(y),    8'h0);
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    step(4'b1000);
    step(4'b0000);
    @(posedge clk);
    #2;
    check("queue_drained", 8'(exp_q.size()), 8'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
